// File: rtl/scan_mux_pkg.sv
// Shared constants and select-mapping helper for the scan mux.
package scan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // True when sel addresses a real channel and the mask enables it.
  function automatic logic sel_mapped(input logic [31:0] mask, input int unsigned sel,
                                      input int unsigned n_in);
    return (sel < n_in) && (sel < 32) && mask[sel[4:0]];
  endfunction

endpackage

// File: rtl/scan_mux_seq.sv
// Select sequencer: host-loaded or self-advancing select with dwell counter and wrap pulse.
module scan_mux_seq
  import scan_mux_pkg::*;
#(
  parameter int N_IN    = 3,
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               mode,
  input  logic               sel_load,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel_q,
  output logic               wrap
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_IN - 1);

  logic [DWELL_W-1:0] dwell_cnt;

  // Out-of-range selects also satisfy sel_q >= LAST, so scan recovers to 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_q     <= '0;
      dwell_cnt <= '0;
      wrap      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (sel_load) begin
        sel_q     <= sel_in;
        dwell_cnt <= '0;
      end else if (mode == MODE_SCAN) begin
        if (dwell_cnt == dwell) begin
          dwell_cnt <= '0;
          if (sel_q >= LAST) begin
            sel_q <= '0;
            wrap  <= 1'b1;
          end else begin
            sel_q <= sel_q + 1'b1;
          end
        end else begin
          dwell_cnt <= dwell_cnt + 1'b1;
        end
      end else begin
        dwell_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/scan_mux_hold.sv
// Registered N-input mux with two masked outputs that hold or load a default when unmapped.
module scan_mux_hold
  import scan_mux_pkg::*;
#(
  parameter int              WIDTH   = 1,
  parameter int              N_IN    = 3,
  parameter int              SEL_W   = 2,
  parameter logic [31:0]     X_MASK  = 32'b0011,
  parameter logic [31:0]     Y_MASK  = 32'b0101,
  parameter bit              X_HOLD  = 1'b1,
  parameter bit              Y_HOLD  = 1'b1,
  parameter logic [WIDTH-1:0] X_DFLT = '0,
  parameter logic [WIDTH-1:0] Y_DFLT = '0,
  parameter int              DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mode,
  input  logic                  sel_load,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic [N_IN*WIDTH-1:0] din,
  output logic [SEL_W-1:0]      sel_q,
  output logic                  wrap,
  output logic [WIDTH-1:0]      x,
  output logic [WIDTH-1:0]      y,
  output logic                  x_upd,
  output logic                  y_upd
);

  localparam int N_SEL = 1 << SEL_W;

  if (N_IN < 2 || N_IN > N_SEL) begin : g_bad_n_in
    $error("scan_mux_hold: N_IN must be in 2..2**SEL_W");
  end
  if ((X_MASK >> N_SEL) != 0) begin : g_bad_x_mask
    $error("scan_mux_hold: X_MASK has bits beyond 2**SEL_W");
  end
  if ((Y_MASK >> N_SEL) != 0) begin : g_bad_y_mask
    $error("scan_mux_hold: Y_MASK has bits beyond 2**SEL_W");
  end

  scan_mux_seq #(
    .N_IN    (N_IN),
    .SEL_W   (SEL_W),
    .DWELL_W (DWELL_W)
  ) u_seq (
    .clk      (clk),
    .reset_n  (reset_n),
    .mode     (mode),
    .sel_load (sel_load),
    .sel_in   (sel_in),
    .dwell    (dwell),
    .sel_q    (sel_q),
    .wrap     (wrap)
  );

  // Pad to a full power-of-two table so any sel_q indexes safely.
  logic [WIDTH-1:0] chan [N_SEL];
  for (genvar k = 0; k < N_SEL; k++) begin : g_chan
    if (k < N_IN) begin : g_real
      assign chan[k] = din[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign chan[k] = '0;
    end
  end

  logic x_map, y_map;
  assign x_map = sel_mapped(X_MASK, 32'(sel_q), N_IN);
  assign y_map = sel_mapped(Y_MASK, 32'(sel_q), N_IN);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x     <= X_DFLT;
      y     <= Y_DFLT;
      x_upd <= 1'b0;
      y_upd <= 1'b0;
    end else begin
      x_upd <= x_map;
      y_upd <= y_map;
      if (x_map)        x <= chan[sel_q];
      else if (!X_HOLD) x <= X_DFLT;
      if (y_map)        y <= chan[sel_q];
      else if (!Y_HOLD) y <= Y_DFLT;
    end
  end

endmodule

// File: tb/tb_scan_mux_hold.sv
// Directed bench: default instance plus an X_HOLD=0 / X_DFLT=1 instance on shared stimulus.
module tb_scan_mux_hold;

  logic       clk;
  logic       reset_n;
  logic       mode;
  logic       sel_load;
  logic [1:0] sel_in;
  logic [7:0] dwell;
  logic [2:0] din;

  logic [1:0] sel_q, sel_q2;
  logic       wrap, wrap2, x, x2, y, y2, x_upd, x_upd2, y_upd, y_upd2;

  int vectors = 0;
  int miscompares = 0;

  scan_mux_hold dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .sel_load(sel_load), .sel_in(sel_in),
    .dwell(dwell), .din(din), .sel_q(sel_q), .wrap(wrap), .x(x), .y(y),
    .x_upd(x_upd), .y_upd(y_upd)
  );

  scan_mux_hold #(.X_HOLD(1'b0), .X_DFLT(1'b1)) dut2 (
    .clk(clk), .reset_n(reset_n), .mode(mode), .sel_load(sel_load), .sel_in(sel_in),
    .dwell(dwell), .din(din), .sel_q(sel_q2), .wrap(wrap2), .x(x2), .y(y2),
    .x_upd(x_upd2), .y_upd(y_upd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation packing for both instances: {sel_q, wrap, x, y, x_upd, y_upd}.
  wire [6:0] obs  = {sel_q, wrap, x, y, x_upd, y_upd};
  wire [6:0] obs2 = {sel_q2, wrap2, x2, y2, x_upd2, y_upd2};
  wire [2:0] seqo = {sel_q, wrap};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mode = 1'b0; sel_load = 1'b0; sel_in = 2'd0; dwell = 8'd0; din = 3'b111;
    tick();
    din = 3'b000;
    tick();
    vectors++;
    if (obs !== 7'b00_0_0_0_0_0) begin
      miscompares++; $display("FAIL reset_state got %b exp %b", obs, 7'b00_0_0_0_0_0);
    end
    vectors++;
    if (obs2 !== 7'b00_0_1_0_0_0) begin
      miscompares++; $display("FAIL reset_state_dflt got %b exp %b", obs2, 7'b00_0_1_0_0_0);
    end
    reset_n = 1'b1; din = 3'b001;
    tick();
    vectors++;
    if (obs !== 7'b00_0_1_1_1_1) begin
      miscompares++; $display("FAIL reset_release got %b exp %b", obs, 7'b00_0_1_1_1_1);
    end
  endtask

  task automatic test_manual_map();
    sel_load = 1'b1; sel_in = 2'd1; din = 3'b000;
    tick();
    vectors++;
    if (obs !== 7'b01_0_0_0_1_1) begin
      miscompares++; $display("FAIL load_sel1 got %b exp %b", obs, 7'b01_0_0_0_1_1);
    end
    sel_load = 1'b0; din = 3'b010;
    tick();
    vectors++;
    if (obs !== 7'b01_0_1_0_1_0) begin
      miscompares++; $display("FAIL x_mapped_sel1 got %b exp %b", obs, 7'b01_0_1_0_1_0);
    end
    sel_load = 1'b1; sel_in = 2'd2; din = 3'b110;
    tick();
    vectors++;
    if (obs !== 7'b10_0_1_0_1_0) begin
      miscompares++; $display("FAIL load_sel2 got %b exp %b", obs, 7'b10_0_1_0_1_0);
    end
    sel_load = 1'b0; din = 3'b100;
    tick();
    vectors++;
    if (obs !== 7'b10_0_1_1_0_1) begin
      miscompares++; $display("FAIL y_mapped_sel2 got %b exp %b", obs, 7'b10_0_1_1_0_1);
    end
  endtask

  task automatic test_unmapped();
    logic [2:0] pat [4] = '{3'b111, 3'b000, 3'b101, 3'b010};
    sel_load = 1'b1; sel_in = 2'd1; din = 3'b000;
    tick();
    sel_in = 2'd3;
    tick();
    vectors++;
    if (obs !== 7'b11_0_0_0_1_0) begin
      miscompares++; $display("FAIL load_sel3 got %b exp %b", obs, 7'b11_0_0_0_1_0);
    end
    vectors++;
    if (obs2 !== 7'b11_0_0_0_1_0) begin
      miscompares++; $display("FAIL load_sel3_dflt got %b exp %b", obs2, 7'b11_0_0_0_1_0);
    end
    sel_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din = pat[i];
      tick();
      vectors++;
      if (obs !== 7'b11_0_0_0_0_0) begin
        miscompares++; $display("FAIL unmapped_hold[%0d] got %b exp %b", i, obs, 7'b11_0_0_0_0_0);
      end
      vectors++;
      if (obs2 !== 7'b11_0_1_0_0_0) begin
        miscompares++; $display("FAIL unmapped_dflt[%0d] got %b exp %b", i, obs2, 7'b11_0_1_0_0_0);
      end
    end
  endtask

  task automatic test_scan_dwell0();
    logic [2:0] exp_seq [6] = '{3'b01_0, 3'b10_0, 3'b00_1, 3'b01_0, 3'b10_0, 3'b00_1};
    mode = 1'b1; dwell = 8'd0; sel_load = 1'b1; sel_in = 2'd0;
    tick();
    vectors++;
    if (seqo !== 3'b00_0) begin
      miscompares++; $display("FAIL scan0_start got %b exp %b", seqo, 3'b00_0);
    end
    sel_load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (seqo !== exp_seq[i]) begin
        miscompares++; $display("FAIL scan0_step[%0d] got %b exp %b", i, seqo, exp_seq[i]);
      end
    end
  endtask

  task automatic test_scan_dwell3();
    logic [2:0] e;
    mode = 1'b1; dwell = 8'd3; sel_load = 1'b1; sel_in = 2'd0;
    tick();
    sel_load = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      e = (i == 4) ? 3'b01_0 : 3'b00_0;
      vectors++;
      if (seqo !== e) begin
        miscompares++; $display("FAIL dwell3_step[%0d] got %b exp %b", i, seqo, e);
      end
    end
    tick();
    tick();
    sel_load = 1'b1; sel_in = 2'd2;
    tick();
    vectors++;
    if (seqo !== 3'b10_0) begin
      miscompares++; $display("FAIL dwell3_midload got %b exp %b", seqo, 3'b10_0);
    end
    sel_load = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      e = (i == 4) ? 3'b00_1 : 3'b10_0;
      vectors++;
      if (seqo !== e) begin
        miscompares++; $display("FAIL dwell3_wrap[%0d] got %b exp %b", i, seqo, e);
      end
    end
    tick();
    tick();
    mode = 1'b0;
    tick();
    mode = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      e = (i == 4) ? 3'b01_0 : 3'b00_0;
      vectors++;
      if (seqo !== e) begin
        miscompares++; $display("FAIL mode_toggle[%0d] got %b exp %b", i, seqo, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    dwell = 8'd0;
    tick();
    vectors++;
    if (seqo !== 3'b10_0) begin
      miscompares++; $display("FAIL b2b_pre got %b exp %b", seqo, 3'b10_0);
    end
    sel_load = 1'b1; sel_in = 2'd1;
    tick();
    vectors++;
    if (seqo !== 3'b01_0) begin
      miscompares++; $display("FAIL load_beats_wrap got %b exp %b", seqo, 3'b01_0);
    end
    sel_in = 2'd3;
    tick();
    sel_load = 1'b0;
    tick();
    vectors++;
    if (seqo !== 3'b00_1) begin
      miscompares++; $display("FAIL oor_scan_wrap got %b exp %b", seqo, 3'b00_1);
    end
  endtask

  task automatic test_reset_scan();
    logic [2:0] e;
    mode = 1'b1; dwell = 8'd3; sel_load = 1'b1; sel_in = 2'd2; din = 3'b111;
    tick();
    sel_load = 1'b0;
    tick();
    tick();
    vectors++;
    if (seqo !== 3'b10_0) begin
      miscompares++; $display("FAIL prereset_sel got %b exp %b", seqo, 3'b10_0);
    end
    reset_n = 1'b0;
    tick();
    vectors++;
    if (obs !== 7'b00_0_0_0_0_0) begin
      miscompares++; $display("FAIL midscan_reset got %b exp %b", obs, 7'b00_0_0_0_0_0);
    end
    vectors++;
    if (obs2 !== 7'b00_0_1_0_0_0) begin
      miscompares++; $display("FAIL midscan_reset_dflt got %b exp %b", obs2, 7'b00_0_1_0_0_0);
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      e = (i == 4) ? 3'b01_0 : 3'b00_0;
      vectors++;
      if (seqo !== e) begin
        miscompares++; $display("FAIL post_reset_step[%0d] got %b exp %b", i, seqo, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual_map();
    test_unmapped();
    test_scan_dwell0();
    test_scan_dwell3();
    test_back_to_back();
    test_reset_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
